or1200_fwd_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the ID-stage operand muxes. It tracks destination registers of instructions in EX and WB and drives the sel_a/sel_b selects. When a consumer in ID depends on a load still pending in EX, it stalls ID and inserts an EX bubble until the load completes. It sits between instruction decode and the operand muxes. Its stall output is ORed into id_freeze by the freeze unit.

---
 rtl/or1200_fwd_pkg.sv | 29 ++
 rtl/or1200_fwd_match.sv | 22 ++
 rtl/or1200_fwd_ctrl.sv | 135 +++++++++++++
 tb/tb_or1200_fwd_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_fwd_pkg.sv
// rtl/or1200_fwd_pkg.sv - shared encodings and types for the forwarding/load-use controller
package or1200_fwd_pkg;

   localparam int FWD_AW = 5;

   localparam logic [1:0] SEL_RF      = 2'd0;
   localparam logic [1:0] SEL_IMM     = 2'd1;
   localparam logic [1:0] SEL_EX_FORW = 2'd2;
   localparam logic [1:0] SEL_WB_FORW = 2'd3;

   typedef enum logic {
      RUN     = 1'b0,
      LU_WAIT = 1'b1
   } lu_state_t;

   typedef struct packed {
      logic [FWD_AW-1:0] rd_addr;
      logic              rfwb;
      logic              is_load;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '0;

   // EX wins over WB because it holds the younger write to the same register.
   function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_wb);
      return hit_ex ? SEL_EX_FORW : (hit_wb ? SEL_WB_FORW : SEL_RF);
   endfunction

endpackage

// File: rtl/or1200_fwd_match.sv
// rtl/or1200_fwd_match.sv - EX/WB destination comparator for one ID source operand
module or1200_fwd_match #(
   parameter int AW = 5
) (
   input  logic          rf_en,
   input  logic [AW-1:0] rf_addr,
   input  logic          ex_rfwb,
   input  logic [AW-1:0] ex_rd_addr,
   input  logic          wb_rfwb,
   input  logic [AW-1:0] wb_rd_addr,
   output logic          hit_ex,
   output logic          hit_wb
);

   // r0 is hard-wired zero, so a write to it must never be forwarded.
   logic addr_nz;
   assign addr_nz = |rf_addr;

   assign hit_ex = rf_en && addr_nz && ex_rfwb && (ex_rd_addr == rf_addr);
   assign hit_wb = rf_en && addr_nz && wb_rfwb && (wb_rd_addr == rf_addr);

endmodule

// File: rtl/or1200_fwd_ctrl.sv
// rtl/or1200_fwd_ctrl.sv - operand forwarding selects and load-use stall control for ID
module or1200_fwd_ctrl
   import or1200_fwd_pkg::*;
#(
   parameter int AW        = FWD_AW,
   parameter int SEL_WIDTH = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_freeze,
   input  logic                 flush,
   input  logic                 id_valid,
   input  logic [AW-1:0]        id_rfa_addr,
   input  logic [AW-1:0]        id_rfb_addr,
   input  logic                 id_rfa_en,
   input  logic                 id_rfb_en,
   input  logic                 id_imm,
   input  logic                 id_rfwb,
   input  logic [AW-1:0]        id_rd_addr,
   input  logic                 id_is_load,
   input  logic                 lsu_done,
   output logic [SEL_WIDTH-1:0] sel_a,
   output logic [SEL_WIDTH-1:0] sel_b,
   output logic                 hazard_stall,
   output logic [AW-1:0]        ex_rd_addr,
   output logic                 ex_rfwb,
   output logic [AW-1:0]        wb_rd_addr,
   output logic                 wb_rfwb,
   output logic [CNT_WIDTH-1:0] lu_stall_cnt
);

   stage_t    ex_q, wb_q, id_st;
   lu_state_t state_q, state_d;
   logic      hit_a_ex, hit_a_wb, hit_b_ex, hit_b_wb;
   logic      lu_hit, id_adv, ex_adv, load_hold;

   assign ex_rd_addr = AW'(ex_q.rd_addr);
   assign ex_rfwb    = ex_q.rfwb;
   assign wb_rd_addr = AW'(wb_q.rd_addr);
   assign wb_rfwb    = wb_q.rfwb;

   always_comb begin
      id_st         = STAGE_BUBBLE;
      id_st.rd_addr = FWD_AW'(id_rd_addr);
      id_st.rfwb    = id_valid && id_rfwb;
      id_st.is_load = id_valid && id_is_load;
   end

   or1200_fwd_match #(.AW(AW)) u_match_a (
      .rf_en      (id_rfa_en),
      .rf_addr    (id_rfa_addr),
      .ex_rfwb    (ex_rfwb),
      .ex_rd_addr (ex_rd_addr),
      .wb_rfwb    (wb_rfwb),
      .wb_rd_addr (wb_rd_addr),
      .hit_ex     (hit_a_ex),
      .hit_wb     (hit_a_wb)
   );

   or1200_fwd_match #(.AW(AW)) u_match_b (
      .rf_en      (id_rfb_en),
      .rf_addr    (id_rfb_addr),
      .ex_rfwb    (ex_rfwb),
      .ex_rd_addr (ex_rd_addr),
      .wb_rfwb    (wb_rfwb),
      .wb_rd_addr (wb_rd_addr),
      .hit_ex     (hit_b_ex),
      .hit_wb     (hit_b_wb)
   );

   assign sel_a = SEL_WIDTH'(fwd_sel(hit_a_ex, hit_a_wb));
   assign sel_b = id_imm ? SEL_WIDTH'(SEL_IMM) : SEL_WIDTH'(fwd_sel(hit_b_ex, hit_b_wb));

   assign lu_hit = id_valid && ex_q.is_load && ex_q.rfwb &&
                   (hit_a_ex || (!id_imm && hit_b_ex));

   assign ex_adv    = !ex_freeze && !flush;
   assign id_adv    = ex_adv && !hazard_stall;
   assign load_hold = ex_q.is_load && !lsu_done;

   // A pending load parks in EX and WB drains; a non-dependent ID op behind it
   // is expected to be held by the LSU's own freeze.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q <= STAGE_BUBBLE;
         wb_q <= STAGE_BUBBLE;
      end else if (flush) begin
         ex_q <= STAGE_BUBBLE;
         wb_q <= STAGE_BUBBLE;
      end else if (ex_adv) begin
         if (load_hold) begin
            wb_q <= STAGE_BUBBLE;
         end else begin
            wb_q <= ex_q;
            ex_q <= (id_adv && state_q == RUN) ? id_st : STAGE_BUBBLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= RUN;
      else if (flush)
         state_q <= RUN;
      else if (!ex_freeze)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (lu_hit && !lsu_done && !ex_freeze && !flush) state_d = LU_WAIT;
         LU_WAIT: if (lsu_done || flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      hazard_stall = 1'b0;
      case (state_q)
         RUN:     hazard_stall = lu_hit && !lsu_done;
         LU_WAIT: hazard_stall = !lsu_done;
         default: hazard_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lu_stall_cnt <= '0;
      else if (hazard_stall && !ex_freeze && !(&lu_stall_cnt))
         lu_stall_cnt <= lu_stall_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_or1200_fwd_ctrl.sv
// tb/tb_or1200_fwd_ctrl.sv - scoreboard bench for the forwarding/load-use controller
module tb_or1200_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_freeze, flush, id_valid;
   logic [4:0]  id_rfa_addr, id_rfb_addr, id_rd_addr;
   logic        id_rfa_en, id_rfb_en, id_imm, id_rfwb, id_is_load, lsu_done;
   logic [1:0]  sel_a, sel_b;
   logic        hazard_stall, ex_rfwb, wb_rfwb;
   logic [4:0]  ex_rd_addr, wb_rd_addr;
   logic [15:0] lu_stall_cnt;

   or1200_fwd_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ex_freeze    (ex_freeze),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_rfa_addr  (id_rfa_addr),
      .id_rfb_addr  (id_rfb_addr),
      .id_rfa_en    (id_rfa_en),
      .id_rfb_en    (id_rfb_en),
      .id_imm       (id_imm),
      .id_rfwb      (id_rfwb),
      .id_rd_addr   (id_rd_addr),
      .id_is_load   (id_is_load),
      .lsu_done     (lsu_done),
      .sel_a        (sel_a),
      .sel_b        (sel_b),
      .hazard_stall (hazard_stall),
      .ex_rd_addr   (ex_rd_addr),
      .ex_rfwb      (ex_rfwb),
      .wb_rd_addr   (wb_rd_addr),
      .wb_rfwb      (wb_rfwb),
      .lu_stall_cnt (lu_stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       valid;
      logic [4:0] rfa;
      logic       rfa_en;
      logic [4:0] rfb;
      logic       rfb_en;
      logic       imm;
      logic       rfwb;
      logic [4:0] rd;
      logic       is_load;
      logic       done;
      logic       frz;
      logic       fl;
   } stim_t;

   // {sel_a, sel_b, hazard_stall, ex_rfwb, wb_rfwb, lu_stall_cnt}
   typedef struct packed {
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic        stall;
      logic        exw;
      logic        wbw;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] base = 16'd0;

   function automatic stim_t st(input logic v, input logic [4:0] a, input logic ae,
                                input logic [4:0] b, input logic be, input logic imm,
                                input logic wb, input logic [4:0] rd, input logic ld,
                                input logic done, input logic frz, input logic fl);
      stim_t s;
      s.valid = v;  s.rfa = a;   s.rfa_en = ae; s.rfb = b;  s.rfb_en = be; s.imm = imm;
      s.rfwb = wb;  s.rd = rd;   s.is_load = ld; s.done = done; s.frz = frz; s.fl = fl;
      return s;
   endfunction

   function automatic exp_t xp(input logic [1:0] sa, input logic [1:0] sb, input logic stl,
                               input logic exw, input logic wbw, input logic [15:0] cnt);
      exp_t e;
      e.sa = sa; e.sb = sb; e.stall = stl; e.exw = exw; e.wbw = wbw; e.cnt = cnt;
      return e;
   endfunction

   function automatic exp_t observe();
      return {sel_a, sel_b, hazard_stall, ex_rfwb, wb_rfwb, lu_stall_cnt};
   endfunction

   task automatic drive(input stim_t s);
      id_valid = s.valid; id_rfa_addr = s.rfa; id_rfa_en = s.rfa_en;
      id_rfb_addr = s.rfb; id_rfb_en = s.rfb_en; id_imm = s.imm;
      id_rfwb = s.rfwb; id_rd_addr = s.rd; id_is_load = s.is_load;
      lsu_done = s.done; ex_freeze = s.frz; flush = s.fl;
   endtask

   localparam stim_t IDLE = '{valid:1'b0, rfa:5'd0, rfa_en:1'b0, rfb:5'd0, rfb_en:1'b0,
                              imm:1'b0, rfwb:1'b0, rd:5'd0, is_load:1'b0, done:1'b1,
                              frz:1'b0, fl:1'b0};

   task automatic test_reset();
      exp_t got, want;
      drive('0);
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(xp(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset_outputs: observed %h required %h", got, want);
      end
      checks++;
      if ({ex_rd_addr, wb_rd_addr} !== 10'd0) begin
         errors++;
         $display("FAIL reset_addrs: observed ex=%0d wb=%0d required 0/0", ex_rd_addr, wb_rd_addr);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_alu_chain();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,1,1,2,1,0,1,3,0,1,0,0)); e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,3,1,1,1,0,1,6,0,1,0,0)); e.push_back(xp(2,0,0,1,0,base));
      s.push_back(st(1,3,1,6,1,0,0,0,0,1,0,0)); e.push_back(xp(3,2,0,1,1,base));
      s.push_back(st(1,6,1,6,1,0,0,0,0,1,0,0)); e.push_back(xp(3,3,0,0,1,base));
      s.push_back(st(1,0,0,0,0,0,1,9,0,1,0,0)); e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,0,0,0,0,0,1,9,0,1,0,0)); e.push_back(xp(0,0,0,1,0,base));
      s.push_back(st(1,9,1,9,1,0,0,0,0,1,0,0)); e.push_back(xp(2,2,0,1,1,base));
      s.push_back(IDLE);                        e.push_back(xp(0,0,0,0,1,base));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL alu_chain[%0d]: observed %h required %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_imm_override();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,0,0,0,0,1,4,0,1,0,0)); e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,4,1,4,1,1,0,0,0,1,0,0)); e.push_back(xp(2,1,0,1,0,base));
      s.push_back(st(1,4,1,4,1,0,0,0,0,1,0,0)); e.push_back(xp(3,3,0,0,1,base));
      s.push_back(st(1,4,0,4,1,1,0,0,0,1,0,0)); e.push_back(xp(0,1,0,0,0,base));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL imm_override[%0d]: observed %h required %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_r0_and_enable();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,0,0,0,0,1,0,0,1,0,0));   e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,0,1,0,1,0,1,0,0,1,0,0));   e.push_back(xp(0,0,0,1,0,base));
      s.push_back(st(1,0,1,0,1,0,0,0,0,1,0,0));   e.push_back(xp(0,0,0,1,1,base));
      s.push_back(st(1,0,0,0,0,0,1,12,0,1,0,0));  e.push_back(xp(0,0,0,0,1,base));
      s.push_back(st(1,12,0,12,0,0,0,0,0,1,0,0)); e.push_back(xp(0,0,0,1,0,base));
      s.push_back(IDLE);                          e.push_back(xp(0,0,0,0,1,base));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL r0_and_enable[%0d]: observed %h required %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,0,0,0,0,1,5,1,0,0,0)); e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(2,0,1,1,0,base));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(2,0,1,1,0,base+16'd1));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(2,0,1,1,0,base+16'd2));
      s.push_back(st(1,5,1,0,0,0,0,0,0,1,0,0)); e.push_back(xp(2,0,0,1,0,base+16'd3));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(3,0,0,0,1,base+16'd3));
      s.push_back(IDLE);                        e.push_back(xp(0,0,0,0,0,base+16'd3));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL load_use[%0d]: observed %h required %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      base = base + 16'd3;
   endtask

   task automatic test_same_cycle_done();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,0,0,0,0,1,7,1,1,0,0)); e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,0,0,7,1,0,0,0,0,1,0,0)); e.push_back(xp(0,2,0,1,0,base));
      s.push_back(st(1,7,1,0,0,0,0,0,0,1,0,0)); e.push_back(xp(3,0,0,0,1,base));
      s.push_back(IDLE);                        e.push_back(xp(0,0,0,0,0,base));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL same_cycle_done[%0d]: observed %h required %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush_lu_wait();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,0,0,0,0,1,5,1,0,0,0)); e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(2,0,1,1,0,base));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,1)); e.push_back(xp(2,0,1,1,0,base+16'd1));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(0,0,0,0,0,base+16'd2));
      s.push_back(IDLE);                        e.push_back(xp(0,0,0,0,0,base+16'd2));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL flush_lu_wait[%0d]: observed %h required %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      base = base + 16'd2;
   endtask

   task automatic test_ex_freeze();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,0,0,0,0,1,8,0,1,1,0));  e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,8,1,0,0,0,0,0,0,1,1,0));  e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,0,0,0,0,0,1,8,0,1,0,0));  e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,8,1,0,0,0,0,0,0,1,0,0));  e.push_back(xp(2,0,0,1,0,base));
      s.push_back(st(1,0,0,0,0,0,1,10,1,0,0,0)); e.push_back(xp(0,0,0,0,1,base));
      s.push_back(st(1,10,1,0,0,0,0,0,0,0,1,0)); e.push_back(xp(2,0,1,1,0,base));
      s.push_back(st(1,10,1,0,0,0,0,0,0,0,1,0)); e.push_back(xp(2,0,1,1,0,base));
      s.push_back(st(1,10,1,0,0,0,0,0,0,1,0,0)); e.push_back(xp(2,0,0,1,0,base));
      s.push_back(IDLE);                         e.push_back(xp(0,0,0,0,1,base));
      s.push_back(IDLE);                         e.push_back(xp(0,0,0,0,0,base));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL ex_freeze[%0d]: observed %h required %h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,0,0,0,0,1,5,1,0,0,0)); e.push_back(xp(0,0,0,0,0,base));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(2,0,1,1,0,base));
      s.push_back(st(1,5,1,0,0,0,0,0,0,0,0,0)); e.push_back(xp(2,0,1,1,0,base+16'd1));
      for (int i = 0; i < s.size(); i++) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL async_reset_pre[%0d]: observed %h required %h", i, got, want);
         end
         if (i < s.size() - 1) begin
            @(posedge clk); #1;
         end
      end
      #1 rst = 1'b1;
      exp_q.push_back(xp(0,0,0,0,0,16'd0));
      #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL async_reset_mid: observed %h required %h", got, want);
      end
      checks++;
      if (ex_rd_addr !== 5'd0) begin
         errors++;
         $display("FAIL async_reset_ex_rd: observed %0d required 0", ex_rd_addr);
      end
      #1 rst = 1'b0;
      base = 16'd0;
      @(posedge clk); #1;
      drive(IDLE); exp_q.push_back(xp(0,0,0,0,0,base));
      @(negedge clk);
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL async_reset_post: observed %h required %h", got, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_alu_chain();
      test_imm_override();
      test_r0_and_enable();
      test_load_use();
      test_same_cycle_done();
      test_flush_lu_wait();
      test_ex_freeze();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
